spatz_rsp_collector: RTL and testbench

//  Controller-side sink for unit responses (vfu_rsp_t, vlsu_rsp_t, vsldu_rsp_t).

---
 rtl/spatz_rsp_collector.sv | 178 +++++++++++++++++
 tb/tb_spatz_rsp_collector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_rsp_collector.sv
// Response sink for VFU/VLSU/VSLDU: retires one response per cycle, frees its ID
// and queues the matching X-interface result towards the core.
module spatz_rsp_collector #(
   parameter int unsigned NrParallelInstructions = 4,
   parameter int unsigned ResultFifoDepth        = 2,
   localparam int unsigned IdW    = $clog2(NrParallelInstructions),
   localparam int unsigned VfuW   = IdW + 15 + 32 + 5 + 1,
   localparam int unsigned VlsuW  = IdW + 5 + 1,
   localparam int unsigned VslduW = IdW + 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              issue_valid_i,
   input  logic [IdW-1:0]    issue_id_i,
   input  logic [4:0]        issue_xintf_id_i,
   output logic              id_available_o,
   output logic [IdW-1:0]    next_id_o,
   input  logic              vfu_rsp_valid_i,
   output logic              vfu_rsp_ready_o,
   input  logic [VfuW-1:0]   vfu_rsp_i,
   input  logic              vlsu_rsp_valid_i,
   output logic              vlsu_rsp_ready_o,
   input  logic [VlsuW-1:0]  vlsu_rsp_i,
   input  logic              vsldu_rsp_valid_i,
   output logic              vsldu_rsp_ready_o,
   input  logic [VslduW-1:0] vsldu_rsp_i,
   output logic              retire_valid_o,
   output logic [IdW-1:0]    retire_id_o,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [4:0]        result_xintf_id_o,
   output logic [31:0]       result_data_o,
   output logic [4:0]        result_rd_o,
   output logic              result_we_o,
   output logic              result_exc_o,
   output logic              err_o
);

   localparam int unsigned PtrW = (ResultFifoDepth > 1) ? $clog2(ResultFifoDepth) : 1;
   localparam int unsigned CntW = $clog2(ResultFifoDepth + 1);
   localparam logic [PtrW-1:0] PtrMax = PtrW'(ResultFifoDepth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(ResultFifoDepth);

   typedef struct packed {
      logic [4:0]  xid;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        exc;
   } entry_t;

   // Response field layout (MSB first):
   //   vfu   {id, vs2[4:0], vs1[4:0], vd[4:0], result[31:0], rd[4:0], wb}
   //   vlsu  {id, vd[4:0], exc}
   //   vsldu {id, vd[4:0], vs2[4:0]}
   logic [IdW-1:0] vfu_id, vlsu_id, vsldu_id;
   logic [31:0]    vfu_result;
   logic [4:0]     vfu_rd;
   logic           vfu_wb, vlsu_exc;
   logic           unused_fields;

   assign vfu_id        = vfu_rsp_i[VfuW-1 -: IdW];
   assign vfu_result    = vfu_rsp_i[37:6];
   assign vfu_rd        = vfu_rsp_i[5:1];
   assign vfu_wb        = vfu_rsp_i[0];
   assign vlsu_id       = vlsu_rsp_i[VlsuW-1 -: IdW];
   assign vlsu_exc      = vlsu_rsp_i[0];
   assign vsldu_id      = vsldu_rsp_i[VslduW-1 -: IdW];
   assign unused_fields = ^{vfu_rsp_i[52:38], vlsu_rsp_i[5:1], vsldu_rsp_i[9:0]};

   logic [NrParallelInstructions-1:0] busy_q, busy_d;
   logic [4:0]                        xid_q [NrParallelInstructions];
   logic [4:0]                        xid_d [NrParallelInstructions];
   logic                              err_q, err_d;
   logic                              retire_valid_q, retire_valid_d;
   logic [IdW-1:0]                    retire_id_q, retire_id_d;
   entry_t                            mem_q [ResultFifoDepth];
   logic [PtrW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]                   cnt_q, cnt_d;

   logic           pop, push, can_push, acc, acc_hit, issue_err;
   logic [IdW-1:0] acc_id;
   entry_t         acc_entry;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrMax) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pop      = result_valid_o & result_ready_i;
      can_push = (cnt_q != CntFull) | pop;

      vfu_rsp_ready_o   = vfu_rsp_valid_i & can_push;
      vlsu_rsp_ready_o  = !vfu_rsp_valid_i & vlsu_rsp_valid_i & can_push;
      vsldu_rsp_ready_o = !vfu_rsp_valid_i & !vlsu_rsp_valid_i & vsldu_rsp_valid_i & can_push;
      acc = vfu_rsp_ready_o | vlsu_rsp_ready_o | vsldu_rsp_ready_o;

      acc_id    = vsldu_id;
      acc_entry = '0;
      if (vfu_rsp_valid_i) begin
         acc_id         = vfu_id;
         acc_entry.data = vfu_wb ? vfu_result : 32'd0;
         acc_entry.rd   = vfu_rd;
         acc_entry.we   = vfu_wb;
      end else if (vlsu_rsp_valid_i) begin
         acc_id        = vlsu_id;
         acc_entry.exc = vlsu_exc;
      end
      acc_entry.xid = xid_q[acc_id];

      acc_hit = acc & busy_q[acc_id];
      push    = acc_hit;

      // A retire and an issue of the same ID in one cycle is legal: clear, then set.
      busy_d = busy_q;
      xid_d  = xid_q;
      if (acc_hit) busy_d[acc_id] = 1'b0;
      issue_err = issue_valid_i & busy_q[issue_id_i] & !(acc_hit & (acc_id == issue_id_i));
      if (issue_valid_i & !issue_err) begin
         busy_d[issue_id_i] = 1'b1;
         xid_d[issue_id_i]  = issue_xintf_id_i;
      end

      err_d          = err_q | issue_err | (acc & !busy_q[acc_id]);
      retire_valid_d = acc_hit;
      retire_id_d    = acc_hit ? acc_id : '0;

      wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q         <= '0;
         err_q          <= 1'b0;
         retire_valid_q <= 1'b0;
         retire_id_q    <= '0;
         wptr_q         <= '0;
         rptr_q         <= '0;
         cnt_q          <= '0;
         for (int i = 0; i < int'(NrParallelInstructions); i++) xid_q[i] <= '0;
         for (int i = 0; i < int'(ResultFifoDepth); i++) mem_q[i] <= '0;
      end else begin
         busy_q         <= busy_d;
         xid_q          <= xid_d;
         err_q          <= err_d;
         retire_valid_q <= retire_valid_d;
         retire_id_q    <= retire_id_d;
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         cnt_q          <= cnt_d;
         if (push) mem_q[wptr_q] <= acc_entry;
      end
   end

   entry_t head;

   always_comb begin
      id_available_o = ~&busy_q;
      next_id_o      = '0;
      for (int i = int'(NrParallelInstructions) - 1; i >= 0; i--) begin
         if (!busy_q[i]) next_id_o = IdW'(i);
      end
   end

   assign result_valid_o    = (cnt_q != '0);
   assign head              = result_valid_o ? mem_q[rptr_q] : '0;
   assign result_xintf_id_o = head.xid;
   assign result_data_o     = head.data;
   assign result_rd_o       = head.rd;
   assign result_we_o       = head.we;
   assign result_exc_o      = head.exc;
   assign retire_valid_o    = retire_valid_q;
   assign retire_id_o       = retire_id_q;
   assign err_o             = err_q;

endmodule

// File: tb/tb_spatz_rsp_collector.sv
// Directed bench for spatz_rsp_collector: issue/retire, arbitration, FIFO backpressure,
// same-cycle issue+retire, stray responses and mid-operation reset.
module tb_spatz_rsp_collector;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        issue_valid_i;
   logic [1:0]  issue_id_i;
   logic [4:0]  issue_xintf_id_i;
   logic        id_available_o;
   logic [1:0]  next_id_o;
   logic        vfu_rsp_valid_i, vfu_rsp_ready_o;
   logic [54:0] vfu_rsp_i;
   logic        vlsu_rsp_valid_i, vlsu_rsp_ready_o;
   logic [7:0]  vlsu_rsp_i;
   logic        vsldu_rsp_valid_i, vsldu_rsp_ready_o;
   logic [11:0] vsldu_rsp_i;
   logic        retire_valid_o;
   logic [1:0]  retire_id_o;
   logic        result_valid_o, result_ready_i;
   logic [4:0]  result_xintf_id_o;
   logic [31:0] result_data_o;
   logic [4:0]  result_rd_o;
   logic        result_we_o, result_exc_o, err_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   spatz_rsp_collector dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_xintf_id_i(issue_xintf_id_i),
      .id_available_o(id_available_o), .next_id_o(next_id_o),
      .vfu_rsp_valid_i(vfu_rsp_valid_i), .vfu_rsp_ready_o(vfu_rsp_ready_o), .vfu_rsp_i(vfu_rsp_i),
      .vlsu_rsp_valid_i(vlsu_rsp_valid_i), .vlsu_rsp_ready_o(vlsu_rsp_ready_o), .vlsu_rsp_i(vlsu_rsp_i),
      .vsldu_rsp_valid_i(vsldu_rsp_valid_i), .vsldu_rsp_ready_o(vsldu_rsp_ready_o),
      .vsldu_rsp_i(vsldu_rsp_i),
      .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_xintf_id_o(result_xintf_id_o), .result_data_o(result_data_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o), .result_exc_o(result_exc_o),
      .err_o(err_o)
   );

   function automatic logic [54:0] vfu_pk(logic [1:0] id, logic [31:0] res, logic [4:0] rd, logic wb);
      return {id, 5'd3, 5'd2, 5'd1, res, rd, wb};
   endfunction
   function automatic logic [7:0] vlsu_pk(logic [1:0] id, logic exc);
      return {id, 5'd4, exc};
   endfunction
   function automatic logic [11:0] vsldu_pk(logic [1:0] id);
      return {id, 5'd6, 5'd7};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [4:0] xid, input logic [31:0] data,
                          input logic [4:0] rd, input logic we, input logic exc);
      chk({tag, ".valid"}, 32'(result_valid_o), 32'd1);
      chk({tag, ".xid"}, 32'(result_xintf_id_o), 32'(xid));
      chk({tag, ".data"}, result_data_o, data);
      chk({tag, ".rd"}, 32'(result_rd_o), 32'(rd));
      chk({tag, ".we"}, 32'(result_we_o), 32'(we));
      chk({tag, ".exc"}, 32'(result_exc_o), 32'(exc));
   endtask

   task automatic chk_retire(input string tag, input logic v, input logic [1:0] id);
      chk({tag, ".retire_valid"}, 32'(retire_valid_o), 32'(v));
      if (v) chk({tag, ".retire_id"}, 32'(retire_id_o), 32'(id));
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [1:0] id, input logic [4:0] xid);
      issue_valid_i    = 1'b1;
      issue_id_i       = id;
      issue_xintf_id_i = xid;
      step();
      issue_valid_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      issue_valid_i = 1'b0; issue_id_i = '0; issue_xintf_id_i = '0;
      vfu_rsp_valid_i = 1'b0; vfu_rsp_i = '0;
      vlsu_rsp_valid_i = 1'b0; vlsu_rsp_i = '0;
      vsldu_rsp_valid_i = 1'b0; vsldu_rsp_i = '0;
      result_ready_i = 1'b0;
      step(); step();

      // 1. reset state
      chk("rst.id_available", 32'(id_available_o), 32'd1);
      chk("rst.next_id", 32'(next_id_o), 32'd0);
      chk("rst.result_valid", 32'(result_valid_o), 32'd0);
      chk("rst.retire_valid", 32'(retire_valid_o), 32'd0);
      chk("rst.err", 32'(err_o), 32'd0);
      chk("rst.result_data", result_data_o, 32'd0);
      rst_ni = 1'b1;
      step();

      // 2. single VFU writeback
      issue(2'd1, 5'd7);
      chk("t2.next_id", 32'(next_id_o), 32'd0);
      vfu_rsp_valid_i = 1'b1;
      vfu_rsp_i = vfu_pk(2'd1, 32'hDEADBEEF, 5'd5, 1'b1);
      #1 chk("t2.vfu_ready", 32'(vfu_rsp_ready_o), 32'd1);
      step();
      vfu_rsp_valid_i = 1'b0;
      chk_retire("t2", 1'b1, 2'd1);
      chk_res("t2", 5'd7, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
      chk("t2.next_id_after", 32'(next_id_o), 32'd0);
      result_ready_i = 1'b1;
      step();
      chk("t2.popped", 32'(result_valid_o), 32'd0);
      chk_retire("t2.pulse_end", 1'b0, 2'd0);

      // 3. three sources in the same cycle, fixed priority
      issue(2'd0, 5'd10);
      issue(2'd1, 5'd11);
      issue(2'd2, 5'd12);
      chk("t3.next_id", 32'(next_id_o), 32'd3);
      vfu_rsp_valid_i = 1'b1;   vfu_rsp_i = vfu_pk(2'd0, 32'h1234, 5'd3, 1'b0);
      vlsu_rsp_valid_i = 1'b1;  vlsu_rsp_i = vlsu_pk(2'd1, 1'b1);
      vsldu_rsp_valid_i = 1'b1; vsldu_rsp_i = vsldu_pk(2'd2);
      #1;
      chk("t3.c1.vfu_ready", 32'(vfu_rsp_ready_o), 32'd1);
      chk("t3.c1.vlsu_ready", 32'(vlsu_rsp_ready_o), 32'd0);
      chk("t3.c1.vsldu_ready", 32'(vsldu_rsp_ready_o), 32'd0);
      step();
      vfu_rsp_valid_i = 1'b0;
      chk_retire("t3.c1", 1'b1, 2'd0);
      chk_res("t3.c1", 5'd10, 32'd0, 5'd3, 1'b0, 1'b0);
      #1;
      chk("t3.c2.vlsu_ready", 32'(vlsu_rsp_ready_o), 32'd1);
      chk("t3.c2.vsldu_ready", 32'(vsldu_rsp_ready_o), 32'd0);
      step();
      vlsu_rsp_valid_i = 1'b0;
      chk_retire("t3.c2", 1'b1, 2'd1);
      chk_res("t3.c2", 5'd11, 32'd0, 5'd0, 1'b0, 1'b1);
      #1 chk("t3.c3.vsldu_ready", 32'(vsldu_rsp_ready_o), 32'd1);
      step();
      vsldu_rsp_valid_i = 1'b0;
      chk_retire("t3.c3", 1'b1, 2'd2);
      chk_res("t3.c3", 5'd12, 32'd0, 5'd0, 1'b0, 1'b0);
      step();
      chk("t3.empty", 32'(result_valid_o), 32'd0);
      chk("t3.next_id_free", 32'(next_id_o), 32'd0);

      // 4. backpressure with a full two-entry queue
      result_ready_i = 1'b0;
      issue(2'd0, 5'd20);
      issue(2'd1, 5'd21);
      issue(2'd2, 5'd22);
      issue(2'd3, 5'd23);
      chk("t4.id_available_none", 32'(id_available_o), 32'd0);
      chk("t4.next_id_none", 32'(next_id_o), 32'd0);
      vfu_rsp_valid_i = 1'b1; vfu_rsp_i = vfu_pk(2'd0, 32'hA0, 5'd1, 1'b1);
      step();
      vfu_rsp_i = vfu_pk(2'd1, 32'hA1, 5'd2, 1'b1);
      step();
      vfu_rsp_i = vfu_pk(2'd2, 32'hA2, 5'd3, 1'b1);
      #1 chk("t4.full.vfu_ready", 32'(vfu_rsp_ready_o), 32'd0);
      step();
      chk_retire("t4.stall", 1'b0, 2'd0);
      chk_res("t4.stall", 5'd20, 32'hA0, 5'd1, 1'b1, 1'b0);
      chk("t4.stall.vfu_ready", 32'(vfu_rsp_ready_o), 32'd0);
      result_ready_i = 1'b1;
      #1 chk("t4.pushpop.vfu_ready", 32'(vfu_rsp_ready_o), 32'd1);
      step();
      vfu_rsp_valid_i = 1'b0;
      chk_retire("t4.pushpop", 1'b1, 2'd2);
      chk_res("t4.second", 5'd21, 32'hA1, 5'd2, 1'b1, 1'b0);
      step();
      chk_res("t4.third", 5'd22, 32'hA2, 5'd3, 1'b1, 1'b0);
      step();
      chk("t4.empty", 32'(result_valid_o), 32'd0);

      // 5. same-cycle issue and retire of id3, then stray VLSU response
      issue_valid_i = 1'b1; issue_id_i = 2'd3; issue_xintf_id_i = 5'd31;
      vfu_rsp_valid_i = 1'b1; vfu_rsp_i = vfu_pk(2'd3, 32'h33, 5'd4, 1'b1);
      step();
      issue_valid_i = 1'b0; vfu_rsp_valid_i = 1'b0;
      chk_retire("t5.same", 1'b1, 2'd3);
      chk_res("t5.same", 5'd23, 32'h33, 5'd4, 1'b1, 1'b0);
      chk("t5.same.err", 32'(err_o), 32'd0);
      step();
      vlsu_rsp_valid_i = 1'b1; vlsu_rsp_i = vlsu_pk(2'd3, 1'b0);
      step();
      vlsu_rsp_valid_i = 1'b0;
      chk_retire("t5.still_busy", 1'b1, 2'd3);
      chk_res("t5.still_busy", 5'd31, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("t5.still_busy.err", 32'(err_o), 32'd0);
      step();
      vlsu_rsp_valid_i = 1'b1; vlsu_rsp_i = vlsu_pk(2'd3, 1'b1);
      #1 chk("t5.stray.vlsu_ready", 32'(vlsu_rsp_ready_o), 32'd1);
      step();
      vlsu_rsp_valid_i = 1'b0;
      chk_retire("t5.stray", 1'b0, 2'd0);
      chk("t5.stray.err", 32'(err_o), 32'd1);
      chk("t5.stray.no_result", 32'(result_valid_o), 32'd0);

      // 6. reset with queued results and in-flight IDs
      result_ready_i = 1'b0;
      issue(2'd0, 5'd1);
      issue(2'd1, 5'd2);
      issue(2'd2, 5'd3);
      vfu_rsp_valid_i = 1'b1; vfu_rsp_i = vfu_pk(2'd0, 32'hB0, 5'd1, 1'b1);
      step();
      vfu_rsp_i = vfu_pk(2'd1, 32'hB1, 5'd2, 1'b1);
      step();
      vfu_rsp_valid_i = 1'b0;
      chk_res("t6.filled", 5'd1, 32'hB0, 5'd1, 1'b1, 1'b0);
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      chk("t6.result_valid", 32'(result_valid_o), 32'd0);
      chk("t6.err", 32'(err_o), 32'd0);
      chk("t6.id_available", 32'(id_available_o), 32'd1);
      chk("t6.next_id", 32'(next_id_o), 32'd0);
      chk("t6.retire_valid", 32'(retire_valid_o), 32'd0);
      vfu_rsp_valid_i = 1'b1; vfu_rsp_i = vfu_pk(2'd2, 32'hB2, 5'd3, 1'b1);
      step();
      vfu_rsp_valid_i = 1'b0;
      chk("t6.id2_freed.err", 32'(err_o), 32'd1);
      chk("t6.id2_freed.no_result", 32'(result_valid_o), 32'd0);
      chk_retire("t6.id2_freed", 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
